// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer scheduler: FSM states, ROM geometry,
// pattern start addresses and the note-code to divider-preload table.
package buzzer_pkg;

  localparam int unsigned RomAw = 6;
  localparam int unsigned RomDw = 9;

  localparam logic [13:0] RestPreload = 14'd16383;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap
  } state_e;

  localparam logic [RomAw-1:0] P0Start = 6'd0;
  localparam logic [RomAw-1:0] P1Start = 6'd4;
  localparam logic [RomAw-1:0] P2Start = 6'd8;
  localparam logic [RomAw-1:0] P3Start = 6'd16;

  function automatic logic [RomAw-1:0] pattern_start(input logic [1:0] id);
    logic [RomAw-1:0] addr;
    case (id)
      2'd0:    addr = P0Start;
      2'd1:    addr = P1Start;
      2'd2:    addr = P2Start;
      default: addr = P3Start;
    endcase
    return addr;
  endfunction

  // Unlisted codes fall through to the rest preload.
  function automatic logic [13:0] note_preload(input logic [4:0] note);
    logic [13:0] pre;
    case (note)
      5'd1:    pre = 14'd4916;
      5'd2:    pre = 14'd6168;
      5'd3:    pre = 14'd7281;
      5'd4:    pre = 14'd7791;
      5'd5:    pre = 14'd8730;
      5'd6:    pre = 14'd9565;
      5'd7:    pre = 14'd10310;
      5'd11:   pre = 14'd10647;
      5'd12:   pre = 14'd11272;
      5'd13:   pre = 14'd11831;
      5'd14:   pre = 14'd12087;
      5'd15:   pre = 14'd12556;
      5'd16:   pre = 14'd12974;
      5'd17:   pre = 14'd13346;
      5'd21:   pre = 14'd13516;
      5'd22:   pre = 14'd13829;
      5'd23:   pre = 14'd14108;
      5'd24:   pre = 14'd14236;
      5'd25:   pre = 14'd14470;
      5'd26:   pre = 14'd14678;
      5'd27:   pre = 14'd14864;
      default: pre = RestPreload;
    endcase
    return pre;
  endfunction

  function automatic logic note_is_rest(input logic [4:0] note);
    return note_preload(note) == RestPreload;
  endfunction

  function automatic logic [RomDw-1:0] rom_word(input logic last, input logic [4:0] note,
                                                input logic [2:0] dur);
    return {last, note, dur};
  endfunction

endpackage

// File: rtl/buzzer_pattern_rom.sv
// Note-pattern ROM, 64 x {last, note[4:0], dur[2:0]}, registered read (1-cycle latency).
module buzzer_pattern_rom
  import buzzer_pkg::*;
(
  input  logic             clk,
  input  logic [RomAw-1:0] addr,
  output logic [RomDw-1:0] data
);

  logic [RomDw-1:0] word;

  always_comb begin
    word = '0;
    case (addr)
      // P0: answer-ack beep
      6'd0:    word = rom_word(1'b1, 5'd15, 3'd1);
      // P1: timeout alarm
      6'd4:    word = rom_word(1'b0, 5'd21, 3'd2);
      6'd5:    word = rom_word(1'b0, 5'd0,  3'd1);
      6'd6:    word = rom_word(1'b1, 5'd21, 3'd2);
      // P2: winner jingle
      6'd8:    word = rom_word(1'b0, 5'd11, 3'd1);
      6'd9:    word = rom_word(1'b0, 5'd13, 3'd1);
      6'd10:   word = rom_word(1'b0, 5'd15, 3'd1);
      6'd11:   word = rom_word(1'b0, 5'd21, 3'd2);
      6'd12:   word = rom_word(1'b0, 5'd15, 3'd1);
      6'd13:   word = rom_word(1'b0, 5'd21, 3'd1);
      6'd14:   word = rom_word(1'b0, 5'd23, 3'd1);
      6'd15:   word = rom_word(1'b1, 5'd25, 3'd2);
      // P3: spare source when NREQ = 4
      6'd16:   word = rom_word(1'b0, 5'd25, 3'd1);
      6'd17:   word = rom_word(1'b1, 5'd27, 3'd2);
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= word;
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Fixed-priority owner of the shared tone generator: grants the highest requester,
// steps its note pattern at beat rate and drives divider preload and enable.
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned BEAT_DIV = 12_500_000,
  parameter int unsigned GAP_CYC  = 1_250_000,
  parameter int unsigned PRE_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             abort,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [1:0]       active_id,
  output logic [PRE_W-1:0] tone_preload,
  output logic             tone_en
);

  localparam int unsigned Bcw = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int unsigned Gcw = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PRE_W-1:0] Rest = '1;

  state_e           state_q;
  logic [RomAw-1:0] addr_q;
  logic [RomAw-1:0] rom_addr;
  logic [RomDw-1:0] rom_data;
  logic [Bcw-1:0]   beat_cnt_q;
  logic [2:0]       beat_num_q;
  logic [2:0]       dur_m1_q;
  logic [Gcw-1:0]   gap_cnt_q;
  logic             last_q;

  logic             hi_any;
  logic [1:0]       hi_idx;
  logic [NREQ-1:0]  hi_oh;
  logic [NREQ-1:0]  act_oh;
  logic             grant;
  logic             preempt;
  logic             beat_wrap;
  logic             gap_end;
  logic [4:0]       rom_note;
  logic [2:0]       rom_dur;

  assign rom_note = rom_data[7:3];
  assign rom_dur  = rom_data[2:0];

  // Highest set request index; later iterations override earlier ones.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = 2'd0;
    hi_oh  = '0;
    act_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        hi_any = 1'b1;
        hi_idx = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      hi_oh[i]  = (2'(i) == hi_idx);
      act_oh[i] = (2'(i) == active_id);
    end
  end

  assign grant     = (state_q == StIdle) && hi_any;
  assign preempt   = (state_q != StIdle) && !abort && hi_any && (hi_idx > active_id);
  assign beat_wrap = (beat_cnt_q == Bcw'(BEAT_DIV - 1));
  assign gap_end   = (gap_cnt_q == Gcw'(GAP_CYC - 1));

  // The ROM registers the address chosen at the transition edge, so its word is
  // already valid during the LOAD cycle that follows.
  always_comb begin
    rom_addr = addr_q;
    if (grant || preempt) begin
      rom_addr = pattern_start(hi_idx);
    end else if ((state_q == StGap) && gap_end && !last_q) begin
      rom_addr = addr_q + 1'b1;
    end
  end

  buzzer_pattern_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      beat_num_q   <= '0;
      dur_m1_q     <= '0;
      gap_cnt_q    <= '0;
      last_q       <= 1'b0;
      ack          <= '0;
      done         <= '0;
      busy         <= 1'b0;
      active_id    <= 2'd0;
      tone_preload <= Rest;
      tone_en      <= 1'b0;
    end else begin
      ack    <= '0;
      done   <= '0;
      addr_q <= rom_addr;
      if (state_q == StIdle) begin
        if (grant) begin
          ack       <= hi_oh;
          active_id <= hi_idx;
          busy      <= 1'b1;
          state_q   <= StLoad;
        end
      end else if (abort) begin
        done         <= act_oh;
        busy         <= 1'b0;
        tone_en      <= 1'b0;
        tone_preload <= Rest;
        state_q      <= StIdle;
      end else if (preempt) begin
        done         <= act_oh;
        ack          <= hi_oh;
        active_id    <= hi_idx;
        tone_en      <= 1'b0;
        tone_preload <= Rest;
        state_q      <= StLoad;
      end else begin
        unique case (state_q)
          StLoad: begin
            last_q     <= rom_data[8];
            dur_m1_q   <= (rom_dur == 3'd0) ? 3'd0 : rom_dur - 3'd1;
            beat_cnt_q <= '0;
            beat_num_q <= '0;
            if (note_is_rest(rom_note)) begin
              tone_en      <= 1'b0;
              tone_preload <= Rest;
            end else begin
              tone_en      <= 1'b1;
              tone_preload <= PRE_W'(note_preload(rom_note));
            end
            state_q <= StPlay;
          end
          StPlay: begin
            if (beat_wrap) begin
              beat_cnt_q <= '0;
              if (beat_num_q == dur_m1_q) begin
                tone_en      <= 1'b0;
                tone_preload <= Rest;
                gap_cnt_q    <= '0;
                state_q      <= StGap;
              end else begin
                beat_num_q <= beat_num_q + 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
          StGap: begin
            if (gap_end) begin
              if (last_q) begin
                done    <= act_oh;
                busy    <= 1'b0;
                state_q <= StIdle;
              end else begin
                state_q <= StLoad;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler: ack/done/tone-run scoreboard plus
// per-scenario inline timing checks.
module tb_buzzer_scheduler;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned BEAT_DIV = 4;
  localparam int unsigned GAP_CYC  = 2;
  localparam int unsigned PRE_W    = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic             abort = 1'b0;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  done;
  logic             busy;
  logic [1:0]       active_id;
  logic [PRE_W-1:0] tone_preload;
  logic             tone_en;

  buzzer_scheduler #(
    .NREQ     (NREQ),
    .BEAT_DIV (BEAT_DIV),
    .GAP_CYC  (GAP_CYC),
    .PRE_W    (PRE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .abort        (abort),
    .ack          (ack),
    .done         (done),
    .busy         (busy),
    .active_id    (active_id),
    .tone_preload (tone_preload),
    .tone_en      (tone_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PRE_W-1:0] pre;
    int               len;
  } run_t;

  int   exp_ack[$];
  int   exp_done[$];
  run_t exp_tone[$];
  int   checks = 0;
  int   errors = 0;
  bit   tone_mon = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tone(input int pre, input int len);
    run_t r;
    r.pre = PRE_W'(pre);
    r.len = len;
    exp_tone.push_back(r);
  endtask

  task automatic push_p2();
    push_tone(10647, 4); push_tone(11831, 4); push_tone(12556, 4); push_tone(13516, 8);
    push_tone(12556, 4); push_tone(13516, 4); push_tone(14108, 4); push_tone(14470, 8);
  endtask

  task automatic wait_tone(input logic lvl, input int limit, output bit ok);
    int n = 0;
    while (tone_en !== lvl && n < limit) begin
      step();
      n++;
    end
    ok = (tone_en === lvl);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n = 0;
    step();
    while (done === '0 && n < limit) begin
      step();
      n++;
    end
    ok = (done !== '0);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    ok = (busy === 1'b0);
    step();
    step();
  endtask

  // Scoreboard: every ack/done pulse and every completed tone run pops an expectation.
  task automatic monitor();
    bit               in_run = 1'b0;
    bit               run_bad = 1'b0;
    int               run_len = 0;
    logic [PRE_W-1:0] run_pre = '0;
    logic [NREQ-1:0]  oh;
    int               e;
    run_t             r;
    forever begin
      @(negedge clk);
      if (ack !== '0) begin
        checks++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL ack_sb: got ack=%b, expected no ack", ack);
        end else begin
          e = exp_ack.pop_front();
          oh = '0;
          oh[e] = 1'b1;
          if (ack !== oh) begin
            errors++;
            $display("FAIL ack_sb: got ack=%b, expected %b", ack, oh);
          end
        end
      end
      if (done !== '0) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_sb: got done=%b, expected no done", done);
        end else begin
          e = exp_done.pop_front();
          oh = '0;
          oh[e] = 1'b1;
          if (done !== oh) begin
            errors++;
            $display("FAIL done_sb: got done=%b, expected %b", done, oh);
          end
        end
      end
      if (tone_en === 1'b1) begin
        if (!in_run) begin
          in_run  = 1'b1;
          run_len = 0;
          run_pre = tone_preload;
          run_bad = 1'b0;
        end
        run_len++;
        if (tone_preload !== run_pre) run_bad = 1'b1;
      end else if (in_run) begin
        in_run = 1'b0;
        if (tone_mon) begin
          checks++;
          if (exp_tone.size() == 0) begin
            errors++;
            $display("FAIL tone_sb: got run preload=%0d len=%0d, expected no run", run_pre,
                     run_len);
          end else begin
            r = exp_tone.pop_front();
            if (run_pre !== r.pre || run_len != r.len || run_bad) begin
              errors++;
              $display("FAIL tone_sb: got preload=%0d len=%0d unstable=%0b, expected %0d len=%0d",
                       run_pre, run_len, run_bad, r.pre, r.len);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks += 6;
    if (ack !== '0) begin errors++; $display("FAIL rst_ack: got %b, expected 0", ack); end
    if (done !== '0) begin errors++; $display("FAIL rst_done: got %b, expected 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (active_id !== 2'd0) begin
      errors++; $display("FAIL rst_id: got %0d, expected 0", active_id);
    end
    if (tone_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b, expected 0", tone_en); end
    if (tone_preload !== 14'd16383) begin
      errors++; $display("FAIL rst_pre: got %0d, expected 16383", tone_preload);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit ok;
    exp_ack.push_back(0); exp_done.push_back(0); push_tone(12556, 4);
    req = 3'b001;
    step();
    checks += 3;
    if (ack !== 3'b001) begin errors++; $display("FAIL p0_ack: got %b, expected 001", ack); end
    if (busy !== 1'b1) begin errors++; $display("FAIL p0_busy: got %b, expected 1", busy); end
    if (active_id !== 2'd0) begin
      errors++; $display("FAIL p0_id: got %0d, expected 0", active_id);
    end
    step();
    checks += 2;
    if (tone_en !== 1'b1) begin errors++; $display("FAIL p0_en: got %b, expected 1", tone_en); end
    if (tone_preload !== 14'd12556) begin
      errors++; $display("FAIL p0_pre: got %0d, expected 12556", tone_preload);
    end
    step();
    req = '0;
    wait_done(30, ok);
    checks += 2;
    if (done !== 3'b001) begin errors++; $display("FAIL p0_done: got %b, expected 001", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL p0_idle: got %b, expected 0", busy); end
    wait_idle(10, ok);
  endtask

  task automatic test_pattern_rest();
    bit ok;
    int silent;
    exp_ack.push_back(1); exp_done.push_back(1); push_tone(13516, 8); push_tone(13516, 8);
    req = 3'b010;
    step();
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL p1_ack: got %b, expected 010", ack); end
    req = '0;
    wait_tone(1'b1, 10, ok);
    wait_tone(1'b0, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL p1_note_end: got tone_en=1, expected 0"); end
    silent = 0;
    while (tone_en === 1'b0 && silent < 30) begin
      if (silent >= 3 && silent <= 6) begin
        checks++;
        if (tone_preload !== 14'd16383) begin
          errors++; $display("FAIL p1_rest_pre: got %0d, expected 16383", tone_preload);
        end
      end
      silent++;
      step();
    end
    checks++;
    if (silent != 10) begin errors++; $display("FAIL p1_silence: got %0d, expected 10", silent); end
    wait_done(40, ok);
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL p1_done: got %b, expected 010", done); end
    wait_idle(10, ok);
  endtask

  task automatic test_preempt();
    bit ok;
    exp_ack.push_back(0); exp_done.push_back(0); exp_ack.push_back(2); exp_done.push_back(2);
    push_tone(12556, 2);
    push_p2();
    req = 3'b001;
    step();
    req = '0;
    step();
    step();
    req = 3'b100;
    step();
    checks += 2;
    if (done !== 3'b001) begin errors++; $display("FAIL pre_done: got %b, expected 001", done); end
    if (ack !== 3'b100) begin errors++; $display("FAIL pre_ack: got %b, expected 100", ack); end
    req = '0;
    wait_tone(1'b1, 10, ok);
    checks++;
    if (tone_preload !== 14'd10647) begin
      errors++; $display("FAIL pre_first: got %0d, expected 10647", tone_preload);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pre_idle: got busy=1, expected 0"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_ack.push_back(2); exp_ack.push_back(1); exp_ack.push_back(0);
    exp_done.push_back(2); exp_done.push_back(1); exp_done.push_back(0);
    push_p2();
    push_tone(13516, 8); push_tone(13516, 8);
    push_tone(12556, 4);
    req = 3'b100;
    step();
    req = '0;
    wait_tone(1'b1, 10, ok);
    step();
    step();
    req = 3'b011;
    step();
    checks += 3;
    if (ack !== '0) begin errors++; $display("FAIL b2b_nopre_ack: got %b, expected 000", ack); end
    if (done !== '0) begin errors++; $display("FAIL b2b_nopre_done: got %b, expected 000", done); end
    if (active_id !== 2'd2) begin
      errors++; $display("FAIL b2b_id: got %0d, expected 2", active_id);
    end
    wait_done(200, ok);
    checks++;
    if (done !== 3'b100) begin errors++; $display("FAIL b2b_done2: got %b, expected 100", done); end
    step();
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL b2b_ack1: got %b, expected 010", ack); end
    req = 3'b001;
    wait_done(60, ok);
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL b2b_done1: got %b, expected 010", done); end
    step();
    checks++;
    if (ack !== 3'b001) begin errors++; $display("FAIL b2b_ack0: got %b, expected 001", ack); end
    req = '0;
    wait_idle(40, ok);
  endtask

  task automatic test_dropped_req();
    bit ok;
    exp_ack.push_back(1); exp_done.push_back(1); push_tone(13516, 8); push_tone(13516, 8);
    req = 3'b010;
    step();
    req = '0;
    repeat (5) step();
    req = 3'b001;
    step();
    step();
    req = '0;
    wait_done(60, ok);
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL drop_done: got %b, expected 010", done); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ack !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL drop_regrant: got ack=%b busy=%b, expected 000/0", ack, busy);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    exp_ack.push_back(0); exp_done.push_back(0); push_tone(12556, 1);
    req = 3'b001;
    step();
    req = '0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks += 4;
    if (tone_en !== 1'b0) begin errors++; $display("FAIL ab0_en: got %b, expected 0", tone_en); end
    if (tone_preload !== 14'd16383) begin
      errors++; $display("FAIL ab0_pre: got %0d, expected 16383", tone_preload);
    end
    if (done !== 3'b001) begin errors++; $display("FAIL ab0_done: got %b, expected 001", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ab0_busy: got %b, expected 0", busy); end
    step();
    step();
    exp_ack.push_back(1); exp_done.push_back(1); push_tone(13516, 8);
    req = 3'b010;
    step();
    req = '0;
    wait_tone(1'b1, 10, ok);
    wait_tone(1'b0, 20, ok);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks += 4;
    if (tone_en !== 1'b0) begin errors++; $display("FAIL ab1_en: got %b, expected 0", tone_en); end
    if (tone_preload !== 14'd16383) begin
      errors++; $display("FAIL ab1_pre: got %0d, expected 16383", tone_preload);
    end
    if (done !== 3'b010) begin errors++; $display("FAIL ab1_done: got %b, expected 010", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ab1_busy: got %b, expected 0", busy); end
    exp_ack.push_back(0); exp_done.push_back(0); push_tone(12556, 4);
    req = 3'b001;
    step();
    checks++;
    if (ack !== 3'b001) begin errors++; $display("FAIL ab1_idle: got ack=%b, expected 001", ack); end
    req = '0;
    wait_idle(40, ok);
  endtask

  task automatic test_abort_idle();
    bit ok;
    exp_ack.push_back(0); exp_done.push_back(0); push_tone(12556, 4);
    req = 3'b001;
    abort = 1'b1;
    step();
    abort = 1'b0;
    req = '0;
    checks++;
    if (ack !== 3'b001) begin errors++; $display("FAIL abidle_ack: got %b, expected 001", ack); end
    wait_done(30, ok);
    checks++;
    if (done !== 3'b001) begin errors++; $display("FAIL abidle_done: got %b, expected 001", done); end
    wait_idle(10, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    tone_mon = 1'b0;
    exp_ack.push_back(1);
    req = 3'b010;
    step();
    wait_tone(1'b1, 10, ok);
    step();
    step();
    rst = 1'b1;
    step();
    checks += 6;
    if (ack !== '0) begin errors++; $display("FAIL mrst_ack: got %b, expected 0", ack); end
    if (done !== '0) begin errors++; $display("FAIL mrst_done: got %b, expected 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b, expected 0", busy); end
    if (active_id !== 2'd0) begin
      errors++; $display("FAIL mrst_id: got %0d, expected 0", active_id);
    end
    if (tone_en !== 1'b0) begin errors++; $display("FAIL mrst_en: got %b, expected 0", tone_en); end
    if (tone_preload !== 14'd16383) begin
      errors++; $display("FAIL mrst_pre: got %0d, expected 16383", tone_preload);
    end
    rst = 1'b0;
    exp_ack.push_back(1); exp_done.push_back(1);
    step();
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL mrst_regrant: got %b, expected 010", ack); end
    req = '0;
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mrst_idle: got busy=1, expected 0"); end
    tone_mon = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_pattern_rest();
    test_preempt();
    test_back_to_back();
    test_dropped_req();
    test_abort();
    test_abort_idle();
    test_reset_mid();
    repeat (4) step();
    checks += 3;
    if (exp_ack.size() != 0) begin
      errors++; $display("FAIL ack_left: got %0d pending, expected 0", exp_ack.size());
    end
    if (exp_done.size() != 0) begin
      errors++; $display("FAIL done_left: got %0d pending, expected 0", exp_done.size());
    end
    if (exp_tone.size() != 0) begin
      errors++; $display("FAIL tone_left: got %0d pending, expected 0", exp_tone.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 20000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
